// File: rtl/spi_pkg.sv
// spi_pkg: shared types, stream word layout and defaults for the SPI stream arbiter
package spi_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int NUM_REQ = 2;
    localparam logic [15:0] DEFAULT_TIMEOUT_CYC = 16'hFFFF;
    localparam int CMD_MSB = 31;
    localparam int CMD_LSB = 28;
    localparam int ADDR_MSB = 27;
    localparam int ADDR_LSB = 24;
    localparam int LEN_MSB = 23;
    localparam int LEN_LSB = 16;
    localparam int WDATA_MSB = 15;
    localparam int WDATA_LSB = 0;
    function automatic logic [3:0] tx_cmd(input logic [31:0] w);
        return w[CMD_MSB:CMD_LSB];
    endfunction
endpackage

// File: rtl/spi_rr_arb2.sv
// spi_rr_arb2: combinational two-way round-robin picker, the loser of the last grant wins ties
module spi_rr_arb2
    import spi_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] gnt
);
    assign gnt[0] = req[0] & (~req[1] | last_grant);
    assign gnt[1] = req[1] & (~req[0] | ~last_grant);
endmodule

// File: rtl/spi_stream_arbiter.sv
// spi_stream_arbiter: shares one SPI master stream port between two requesters,
// one tx word per grant, grant held until end-of-transmit or watchdog expiry
module spi_stream_arbiter
    import spi_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic        pclk_i,
    input  logic        rst_n_i,
    input  logic [31:0] req0_tx_data_i,
    input  logic        req0_tx_vld_i,
    output logic        req0_tx_rdy_o,
    input  logic [15:0] req0_clk_div_i,
    output logic [31:0] req0_rx_data_o,
    output logic        req0_rx_vld_o,
    input  logic        req0_rx_rdy_i,
    output logic        req0_eot_o,
    input  logic [31:0] req1_tx_data_i,
    input  logic        req1_tx_vld_i,
    output logic        req1_tx_rdy_o,
    input  logic [15:0] req1_clk_div_i,
    output logic [31:0] req1_rx_data_o,
    output logic        req1_rx_vld_o,
    input  logic        req1_rx_rdy_i,
    output logic        req1_eot_o,
    output logic [31:0] m_tx_data_o,
    output logic        m_tx_vld_o,
    input  logic        m_tx_rdy_i,
    input  logic [31:0] m_rx_data_i,
    input  logic        m_rx_vld_i,
    output logic        m_rx_rdy_o,
    input  logic        m_eot_i,
    output logic [15:0] m_clk_div_o,
    output logic        m_clk_div_vld_o,
    output logic [1:0]  grant_o,
    output logic        busy_o,
    output logic        timeout_o
);
    state_t      state;
    logic [1:0]  grant, pick;
    logic        last_grant, tx_done, busy, wd_hit, end_txn, sel_vld;
    logic [15:0] clk_div, cnt;

    spi_rr_arb2 u_arb (
        .req        ({req1_tx_vld_i, req0_tx_vld_i}),
        .last_grant (last_grant),
        .gnt        (pick)
    );

    assign busy    = state == BUSY;
    assign wd_hit  = busy && TIMEOUT_CYC != 16'd0 && cnt == TIMEOUT_CYC - 16'd1;
    assign end_txn = busy && (m_eot_i || wd_hit);
    assign sel_vld = grant[1] ? req1_tx_vld_i : grant[0] & req0_tx_vld_i;

    assign m_tx_vld_o      = sel_vld & ~tx_done;
    assign m_tx_data_o     = grant[1] ? req1_tx_data_i : grant[0] ? req0_tx_data_i : '0;
    assign req0_tx_rdy_o   = grant[0] & m_tx_rdy_i & ~tx_done;
    assign req1_tx_rdy_o   = grant[1] & m_tx_rdy_i & ~tx_done;
    assign req0_rx_data_o  = m_rx_data_i;
    assign req1_rx_data_o  = m_rx_data_i;
    assign req0_rx_vld_o   = grant[0] & m_rx_vld_i;
    assign req1_rx_vld_o   = grant[1] & m_rx_vld_i;
    assign m_rx_rdy_o      = (grant[0] & req0_rx_rdy_i) | (grant[1] & req1_rx_rdy_i);
    assign req0_eot_o      = grant[0] & end_txn;
    assign req1_eot_o      = grant[1] & end_txn;
    // eot wins over a coincident watchdog expiry
    assign timeout_o       = wd_hit & ~m_eot_i;
    assign m_clk_div_o     = clk_div;
    assign m_clk_div_vld_o = busy;
    assign grant_o         = grant;
    assign busy_o          = busy;

    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= 1'b1;
            tx_done    <= 1'b0;
            clk_div    <= '0;
            cnt        <= '0;
        end else if (state == IDLE) begin
            if (|pick) begin
                state   <= BUSY;
                grant   <= pick;
                clk_div <= pick[1] ? req1_clk_div_i : req0_clk_div_i;
                tx_done <= 1'b0;
                cnt     <= '0;
            end
        end else if (end_txn) begin
            state      <= IDLE;
            last_grant <= grant[1];
            grant      <= '0;
        end else begin
            if (m_tx_vld_o && m_tx_rdy_i) tx_done <= 1'b1;
            if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_spi_stream_arbiter.sv
// tb_spi_stream_arbiter: directed stimulus with a scoreboard queue checked by a negedge monitor
module tb_spi_stream_arbiter;
    localparam logic [1:0] EV_TX = 2'd0, EV_RX = 2'd1, EV_EOT = 2'd2;
    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] val;
    } ev_t;

    logic        pclk_i = 1'b0, rst_n_i = 1'b0;
    logic [31:0] req0_tx_data_i = '0, req1_tx_data_i = '0, m_rx_data_i = '0;
    logic        req0_tx_vld_i = 0, req1_tx_vld_i = 0, req0_rx_rdy_i = 0, req1_rx_rdy_i = 0;
    logic [15:0] req0_clk_div_i = '0, req1_clk_div_i = '0;
    logic        m_tx_rdy_i = 0, m_rx_vld_i = 0, m_eot_i = 0;
    logic [31:0] req0_rx_data_o, req1_rx_data_o, m_tx_data_o;
    logic        req0_tx_rdy_o, req1_tx_rdy_o, req0_rx_vld_o, req1_rx_vld_o, req0_eot_o, req1_eot_o;
    logic        m_tx_vld_o, m_rx_rdy_o, m_clk_div_vld_o, busy_o, timeout_o;
    logic [15:0] m_clk_div_o;
    logic [1:0]  grant_o;

    int checks = 0, failures = 0;
    ev_t exp_q[$];

    spi_stream_arbiter #(.TIMEOUT_CYC(16'd16)) dut (
        .pclk_i(pclk_i), .rst_n_i(rst_n_i),
        .req0_tx_data_i(req0_tx_data_i), .req0_tx_vld_i(req0_tx_vld_i), .req0_tx_rdy_o(req0_tx_rdy_o),
        .req0_clk_div_i(req0_clk_div_i), .req0_rx_data_o(req0_rx_data_o), .req0_rx_vld_o(req0_rx_vld_o),
        .req0_rx_rdy_i(req0_rx_rdy_i), .req0_eot_o(req0_eot_o),
        .req1_tx_data_i(req1_tx_data_i), .req1_tx_vld_i(req1_tx_vld_i), .req1_tx_rdy_o(req1_tx_rdy_o),
        .req1_clk_div_i(req1_clk_div_i), .req1_rx_data_o(req1_rx_data_o), .req1_rx_vld_o(req1_rx_vld_o),
        .req1_rx_rdy_i(req1_rx_rdy_i), .req1_eot_o(req1_eot_o),
        .m_tx_data_o(m_tx_data_o), .m_tx_vld_o(m_tx_vld_o), .m_tx_rdy_i(m_tx_rdy_i),
        .m_rx_data_i(m_rx_data_i), .m_rx_vld_i(m_rx_vld_i), .m_rx_rdy_o(m_rx_rdy_o), .m_eot_i(m_eot_i),
        .m_clk_div_o(m_clk_div_o), .m_clk_div_vld_o(m_clk_div_vld_o),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 pclk_i = ~pclk_i;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input logic [63:0] v);
        exp_q.push_back('{kind: k, val: v});
    endtask

    task automatic pop_cmp(input string n, input logic [1:0] k, input logic [63:0] v);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected event actual=%h expected=none", n, v);
        end else begin
            e = exp_q.pop_front();
            chk({n, "_kind"}, {62'd0, k}, {62'd0, e.kind});
            chk(n, v, e.val);
        end
    endtask

    always @(negedge pclk_i) begin
        if (rst_n_i) begin
            if (m_tx_vld_o && m_tx_rdy_i)
                pop_cmp("tx_xfer", EV_TX, {m_tx_data_o, m_clk_div_o, 12'd0, req1_tx_rdy_o, req0_tx_rdy_o, grant_o});
            if (req0_rx_vld_o || req1_rx_vld_o)
                pop_cmp("rx_xfer", EV_RX, {req1_rx_data_o, 30'd0, req1_rx_vld_o, req0_rx_vld_o});
            if (req0_eot_o || req1_eot_o || timeout_o)
                pop_cmp("eot", EV_EOT, {61'd0, timeout_o, req1_eot_o, req0_eot_o});
        end
    end

    initial begin
        step();
        chk("rst_outs", {62'd0, grant_o, busy_o, timeout_o, m_tx_vld_o, m_rx_rdy_o, m_clk_div_vld_o,
                         req0_tx_rdy_o, req1_tx_rdy_o, req0_eot_o, req1_eot_o}, 64'd0);
        chk("rst_div_data", {m_clk_div_o, m_tx_data_o}, 64'd0);
        rst_n_i = 1;
        step();
        // single request from req0
        req0_tx_vld_i = 1; req0_tx_data_i = 32'h1234_ABCD; req0_clk_div_i = 16'd8;
        #1 chk("pre_grant_busy", {63'd0, busy_o}, 64'd0);
        step();
        chk("grant_req0", {44'd0, grant_o, m_clk_div_o, busy_o, m_tx_vld_o}, {44'd0, 2'b01, 16'd8, 2'b11});
        push(EV_TX, {32'h1234_ABCD, 16'd8, 12'd0, 2'b01, 2'b01});
        m_tx_rdy_i = 1;
        #1 chk("req0_tx_rdy", {63'd0, req0_tx_rdy_o}, 64'd1);
        step();
        chk("tx_done_gate", {62'd0, m_tx_vld_o, req0_tx_rdy_o}, 64'd0);
        m_tx_rdy_i = 0;
        push(EV_EOT, {61'd0, 3'b001});
        m_eot_i = 1;
        #1 chk("req0_eot_comb", {63'd0, req0_eot_o}, 64'd1);
        step();
        m_eot_i = 0; req0_tx_vld_i = 0;
        chk("release_idle", {45'd0, busy_o, grant_o, m_clk_div_vld_o, m_clk_div_o}, {48'd0, 16'd8});
        m_eot_i = 1; m_rx_vld_i = 1; req0_rx_rdy_i = 1;
        #1 chk("idle_ignore", {59'd0, req0_eot_o, req1_eot_o, req0_rx_vld_o, req1_rx_vld_o, m_rx_rdy_o}, 64'd0);
        step();
        chk("idle_no_grant", {63'd0, busy_o}, 64'd0);
        m_eot_i = 0; m_rx_vld_i = 0; req0_rx_rdy_i = 0;
        // contention from reset
        rst_n_i = 0;
        step();
        rst_n_i = 1;
        step();
        req0_tx_vld_i = 1; req0_tx_data_i = 32'hA1B2_C3D4; req0_clk_div_i = 16'd3;
        req1_tx_vld_i = 1; req1_tx_data_i = 32'h5E6F_7081; req1_clk_div_i = 16'd5;
        step();
        chk("cont_first_req0", {46'd0, grant_o, m_clk_div_o}, {46'd0, 2'b01, 16'd3});
        push(EV_TX, {32'hA1B2_C3D4, 16'd3, 12'd0, 2'b01, 2'b01});
        m_tx_rdy_i = 1;
        step();
        m_tx_rdy_i = 0;
        push(EV_EOT, {61'd0, 3'b001});
        m_eot_i = 1;
        step();
        m_eot_i = 0; req0_tx_vld_i = 0;
        chk("idle_gap", {61'd0, busy_o, grant_o}, 64'd0);
        step();
        chk("cont_then_req1", {46'd0, grant_o, m_clk_div_o}, {46'd0, 2'b10, 16'd5});
        // rx routing to req1
        push(EV_RX, {32'hDEAD_BEEF, 30'd0, 2'b10});
        m_rx_vld_i = 1; m_rx_data_i = 32'hDEAD_BEEF; req1_rx_rdy_i = 1;
        #1 chk("rx_rdy_follow1", {63'd0, m_rx_rdy_o}, 64'd1);
        step();
        m_rx_vld_i = 0; req1_rx_rdy_i = 0;
        #1 chk("rx_rdy_follow0", {63'd0, m_rx_rdy_o}, 64'd0);
        push(EV_TX, {32'h5E6F_7081, 16'd5, 12'd0, 2'b10, 2'b10});
        m_tx_rdy_i = 1;
        step();
        m_tx_rdy_i = 0; req0_tx_vld_i = 1;
        push(EV_EOT, {61'd0, 3'b010});
        m_eot_i = 1;
        step();
        m_eot_i = 0;
        step();
        chk("cont_again_req0", {62'd0, grant_o}, {62'd0, 2'b01});
        push(EV_EOT, {61'd0, 3'b001});
        m_eot_i = 1;
        step();
        m_eot_i = 0; req0_tx_vld_i = 0; req1_tx_vld_i = 0;
        step();
        // watchdog expiry
        req0_tx_vld_i = 1;
        step();
        chk("wd_grant", {62'd0, grant_o}, {62'd0, 2'b01});
        push(EV_EOT, {61'd0, 3'b101});
        for (int i = 0; i < 15; i++) begin
            chk("wd_early", {63'd0, timeout_o}, 64'd0);
            step();
        end
        chk("wd_fire", {62'd0, timeout_o, req0_eot_o}, {62'd0, 2'b11});
        step();
        req0_tx_vld_i = 0;
        chk("wd_release", {63'd0, busy_o}, 64'd0);
        step();
        // eot coincident with watchdog
        req0_tx_vld_i = 1;
        step();
        push(EV_EOT, {61'd0, 3'b001});
        for (int i = 0; i < 15; i++) step();
        m_eot_i = 1;
        #1 chk("wd_vs_eot", {62'd0, timeout_o, req0_eot_o}, {62'd0, 2'b01});
        step();
        m_eot_i = 0; req0_tx_vld_i = 0;
        chk("wd_vs_eot_idle", {63'd0, busy_o}, 64'd0);
        step();
        // reset mid-BUSY after tx handshake
        req0_tx_vld_i = 1; req0_tx_data_i = 32'h0F1E_2D3C; req0_clk_div_i = 16'h0042;
        step();
        push(EV_TX, {32'h0F1E_2D3C, 16'h0042, 12'd0, 2'b01, 2'b01});
        m_tx_rdy_i = 1;
        step();
        m_tx_rdy_i = 0;
        rst_n_i = 0;
        #1 chk("rst_busy_outs", {52'd0, grant_o, busy_o, timeout_o, m_tx_vld_o, m_rx_rdy_o, m_clk_div_vld_o,
                                 req0_tx_rdy_o, req0_eot_o, req1_eot_o, req0_rx_vld_o, req1_rx_vld_o}, 64'd0);
        chk("rst_busy_div", {m_clk_div_o, m_tx_data_o}, 64'd0);
        req0_tx_vld_i = 0;
        step();
        rst_n_i = 1;
        step();
        req1_tx_vld_i = 1; req1_tx_data_i = 32'h9999_0001; req1_clk_div_i = 16'd7;
        step();
        chk("post_rst_req1", {46'd0, grant_o, m_clk_div_o}, {46'd0, 2'b10, 16'd7});
        push(EV_TX, {32'h9999_0001, 16'd7, 12'd0, 2'b10, 2'b10});
        m_tx_rdy_i = 1;
        step();
        m_tx_rdy_i = 0;
        push(EV_EOT, {61'd0, 3'b010});
        m_eot_i = 1;
        step();
        m_eot_i = 0; req1_tx_vld_i = 0;
        step();
        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
